force_arbiter: RTL and testbench



---
 rtl/force_arbiter_pkg.sv | 28 ++
 rtl/force_arbiter_rr_pick.sv | 45 ++++
 rtl/force_arbiter.sv | 160 ++++++++++++++++
 tb/tb_force_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/force_arbiter_pkg.sv
// force_arbiter_pkg
//   Shared types and helpers for the force arbiter.
//   - state_t      : arbiter FSM states (IDLE, FORCE, RELEASE)
//   - STATS_W      : width of the optional statistics counters
//   - PTR_W        : width of the round-robin pointer and winner index
//                    (sized for the largest supported NUM_REQ of 8)
//   - ptr_wrap_inc : pointer increment that wraps modulo the requester count
package force_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORCE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int STATS_W = 16;
    localparam int PTR_W   = 3;

    // Next round-robin start position after index p, wrapping at n.
    function automatic logic [PTR_W-1:0] ptr_wrap_inc(input logic [PTR_W-1:0] p,
                                                      input int               n);
        if (int'(p) + 1 >= n) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/force_arbiter_rr_pick.sv
// force_arbiter_rr_pick
//   Combinational round-robin picker. Selects the first asserted request at
//   or after the pointer position, wrapping modulo NUM_REQ.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  PTR_W    highest-priority position
//   win     out NUM_REQ  one-hot winner (zero when no request)
//   win_idx out PTR_W    winner index (zero when no request)
//   vld     out 1        at least one request present
module force_arbiter_rr_pick
    import force_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PTR_W-1:0]   win_idx,
    output logic               vld
);

    // Walk priority positions k = 0..NUM_REQ-1 starting at ptr; the inner loop
    // matches the rotated position against each constant index so the request
    // vector is only ever indexed by elaboration-time constants.
    always_comb begin
        win     = '0;
        win_idx = '0;
        vld     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int pos;
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!vld && req[i] && (i == pos)) begin
                    vld     = 1'b1;
                    win[i]  = 1'b1;
                    win_idx = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/force_arbiter.sv
// force_arbiter
//   Shares one forceable signal between NUM_REQ requesters. A round-robin
//   winner has its value and hold count latched; the signal is overridden for
//   max(hold,1) cycles (or until the requester drops req), then one RELEASE
//   cycle pulses done to the owner before the arbiter returns to IDLE.
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   W        width of the forced signal
//   HW       width of each hold-cycle count
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req      [NUM_REQ]  per-requester level request, held until done
//   req_val  [NUM_REQ*W]  force value, slice i for requester i
//   req_hold [NUM_REQ*HW] hold cycles, slice i for requester i
//   drv_val  [W]        normal driver value
//   gnt      [NUM_REQ]  one-hot grant (registered)
//   force_en            force applied (registered)
//   force_val [W]       latched force value
//   sig_out  [W]        force_en ? force_val : drv_val (combinational)
//   done     [NUM_REQ]  one-cycle release pulse to the owner
//   busy                arbiter not in IDLE
// Optional feature (macro FORCE_ARBITER_STATS_EN):
//   grant_cnt     [16]  saturating count of grants
//   early_rel_cnt [16]  saturating count of releases caused by req dropping
module force_arbiter
    import force_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = 1,
    parameter int HW      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*W-1:0]  req_val,
    input  logic [NUM_REQ*HW-1:0] req_hold,
    input  logic [W-1:0]          drv_val,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  force_en,
    output logic [W-1:0]          force_val,
    output logic [W-1:0]          sig_out,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy
`ifdef FORCE_ARBITER_STATS_EN
    ,
    output logic [STATS_W-1:0]    grant_cnt,
    output logic [STATS_W-1:0]    early_rel_cnt
`endif
);

    state_t              state;
    logic [PTR_W-1:0]    ptr;
    logic [HW-1:0]       cnt;

    logic [NUM_REQ-1:0]  pick_win;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_vld;
    logic [W-1:0]        pick_val;
    logic [HW-1:0]       pick_hold;

    logic                req_held;
    logic                last_cycle;

    force_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .vld     (pick_vld)
    );

    // Slice the winner's value and hold count out of the packed inputs.
    always_comb begin
        pick_val  = '0;
        pick_hold = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) begin
                pick_val  = req_val[i*W +: W];
                pick_hold = req_hold[i*HW +: HW];
            end
        end
    end

    // gnt is only non-zero in FORCE, so it doubles as the owner mask there.
    assign req_held   = |(req & gnt);
    // A loaded count of 0 or 1 both mean this is the final forced cycle.
    assign last_cycle = (cnt <= HW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            force_en  <= 1'b0;
            force_val <= '0;
            done      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (pick_vld) begin
                        gnt       <= pick_win;
                        force_en  <= 1'b1;
                        force_val <= pick_val;
                        cnt       <= pick_hold;
                        ptr       <= ptr_wrap_inc(pick_idx, NUM_REQ);
                        state     <= FORCE;
                    end
                end
                FORCE: begin
                    // The cycle already underway stays forced; force_en drops
                    // after this edge whether the hold ran out or req fell.
                    if (last_cycle || !req_held) begin
                        force_en <= 1'b0;
                        gnt      <= '0;
                        done     <= gnt;
                        cnt      <= '0;
                        state    <= RELEASE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    done  <= '0;
                    state <= IDLE;
                end
                default: begin
                    force_en <= 1'b0;
                    gnt      <= '0;
                    done     <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign sig_out = force_en ? force_val : drv_val;

`ifdef FORCE_ARBITER_STATS_EN
    // A release counts as early only when the hold had not already expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt     <= '0;
            early_rel_cnt <= '0;
        end else begin
            if (state == IDLE && pick_vld && grant_cnt != '1) begin
                grant_cnt <= grant_cnt + 1'b1;
            end
            if (state == FORCE && !req_held && !last_cycle && early_rel_cnt != '1) begin
                early_rel_cnt <= early_rel_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_force_arbiter.sv
// tb_force_arbiter
//   Directed bench for force_arbiter (NUM_REQ=4, W=1, HW=8). Each step waits
//   for a rising edge, samples 1 ns later, and compares against hand-derived
//   values. Statistics outputs are checked when FORCE_ARBITER_STATS_EN is set.
module tb_force_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_val;
    logic [31:0] req_hold;
    logic [0:0]  drv_val;
    logic [3:0]  gnt;
    logic        force_en;
    logic [0:0]  force_val;
    logic [0:0]  sig_out;
    logic [3:0]  done;
    logic        busy;
`ifdef FORCE_ARBITER_STATS_EN
    logic [15:0] grant_cnt;
    logic [15:0] early_rel_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    force_arbiter #(
        .NUM_REQ (4),
        .W       (1),
        .HW      (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_val       (req_val),
        .req_hold      (req_hold),
        .drv_val       (drv_val),
        .gnt           (gnt),
        .force_en      (force_en),
        .force_val     (force_val),
        .sig_out       (sig_out),
        .done          (done),
        .busy          (busy)
`ifdef FORCE_ARBITER_STATS_EN
        ,
        .grant_cnt     (grant_cnt),
        .early_rel_cnt (early_rel_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_val  = 4'b0000;
        req_hold = 32'h0;
        drv_val  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_force_en", 32'(force_en), 32'h0);
        chk("rst_force_val", 32'(force_val), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sig_out", 32'(sig_out), 32'h0);
`ifdef FORCE_ARBITER_STATS_EN
        chk("rst_grant_cnt", 32'(grant_cnt), 32'h0);
        chk("rst_early_cnt", 32'(early_rel_cnt), 32'h0);
`endif
        rst_n = 1'b1;
        tick();

        // Round-robin: all four request with hold=1, values 0,1,0,1
        req      = 4'b1111;
        req_val  = 4'b1010;
        req_hold = 32'h01010101;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
            chk("rr_force_en", 32'(force_en), 32'h1);
            chk("rr_force_val", 32'(force_val), 32'((g % 4) & 1));
            tick();
            chk("rr_rel_force_en", 32'(force_en), 32'h0);
            chk("rr_rel_gnt", 32'(gnt), 32'h0);
            chk("rr_done", 32'(done), 32'(4'b0001 << (g % 4)));
            if (g == 4) begin
                req = 4'b0000;
            end
            tick();
            chk("rr_idle_busy", 32'(busy), 32'h0);
            chk("rr_idle_force_en", 32'(force_en), 32'h0);
            chk("rr_idle_done", 32'(done), 32'h0);
        end
        tick();
        chk("rr_quiet_busy", 32'(busy), 32'h0);

        // Single grant: requester 1, value 1, hold 3, driver 0
        req      = 4'b0010;
        req_val  = 4'b0010;
        req_hold = 32'h00000300;
        drv_val  = 1'b0;
        tick();
        chk("sg_gnt", 32'(gnt), 32'h2);
        chk("sg_force_en_1", 32'(force_en), 32'h1);
        chk("sg_sig_out", 32'(sig_out), 32'h1);
        chk("sg_busy", 32'(busy), 32'h1);
        tick();
        chk("sg_force_en_2", 32'(force_en), 32'h1);
        tick();
        chk("sg_force_en_3", 32'(force_en), 32'h1);
        chk("sg_done_early", 32'(done), 32'h0);
        tick();
        chk("sg_rel_force_en", 32'(force_en), 32'h0);
        chk("sg_done", 32'(done), 32'h2);
        chk("sg_rel_gnt", 32'(gnt), 32'h0);
        chk("sg_rel_sig_out", 32'(sig_out), 32'h0);
        req = 4'b0000;
        tick();
        chk("sg_idle_done", 32'(done), 32'h0);
        chk("sg_idle_busy", 32'(busy), 32'h0);
        drv_val = 1'b1;
        #1;
        chk("sg_follow_drv", 32'(sig_out), 32'h1);
        drv_val = 1'b0;

        // Hold zero: requester 0, value 1, forced for exactly one cycle
        req      = 4'b0001;
        req_val  = 4'b0001;
        req_hold = 32'h00000000;
        tick();
        chk("h0_gnt", 32'(gnt), 32'h1);
        chk("h0_force_en", 32'(force_en), 32'h1);
        chk("h0_force_val", 32'(force_val), 32'h1);
        tick();
        chk("h0_rel_force_en", 32'(force_en), 32'h0);
        chk("h0_done", 32'(done), 32'h1);
        req = 4'b0000;
        tick();
        chk("h0_idle_busy", 32'(busy), 32'h0);

        // Early release: requester 2, hold 10, req dropped after two forced cycles
        req      = 4'b0100;
        req_val  = 4'b0100;
        req_hold = 32'h000A0000;
        tick();
        chk("er_gnt", 32'(gnt), 32'h4);
        chk("er_force_en_1", 32'(force_en), 32'h1);
        tick();
        chk("er_force_en_2", 32'(force_en), 32'h1);
        req = 4'b0000;
        tick();
        chk("er_rel_force_en", 32'(force_en), 32'h0);
        chk("er_done", 32'(done), 32'h4);
        tick();
        chk("er_idle_busy", 32'(busy), 32'h0);
`ifdef FORCE_ARBITER_STATS_EN
        chk("er_grant_cnt", 32'(grant_cnt), 32'd8);
        chk("er_early_cnt", 32'(early_rel_cnt), 32'd1);
`endif

        // Value latch: requester 1 changes its value mid-force
        req      = 4'b0010;
        req_val  = 4'b0010;
        req_hold = 32'h00000300;
        drv_val  = 1'b0;
        tick();
        chk("vl_gnt", 32'(gnt), 32'h2);
        chk("vl_force_val_1", 32'(force_val), 32'h1);
        req_val = 4'b0000;
        tick();
        chk("vl_force_val_2", 32'(force_val), 32'h1);
        chk("vl_sig_out", 32'(sig_out), 32'h1);
        tick();
        chk("vl_force_val_3", 32'(force_val), 32'h1);
        chk("vl_force_en_3", 32'(force_en), 32'h1);
        tick();
        chk("vl_rel_force_en", 32'(force_en), 32'h0);
        chk("vl_rel_sig_out", 32'(sig_out), 32'h0);
        req = 4'b0000;
        tick();

        // Asynchronous reset mid-force, then requesters 3 and 0 together
        req      = 4'b0100;
        req_val  = 4'b0100;
        req_hold = 32'h000A0000;
        drv_val  = 1'b0;
        tick();
        chk("ar_force_en", 32'(force_en), 32'h1);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_force_en_drop", 32'(force_en), 32'h0);
        chk("ar_gnt_drop", 32'(gnt), 32'h0);
        chk("ar_busy_drop", 32'(busy), 32'h0);
        chk("ar_sig_out", 32'(sig_out), 32'h0);
`ifdef FORCE_ARBITER_STATS_EN
        chk("ar_grant_cnt", 32'(grant_cnt), 32'h0);
`endif
        req      = 4'b1001;
        req_val  = 4'b0001;
        req_hold = 32'h02000002;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_first_gnt", 32'(gnt), 32'h1);
        chk("ar_first_val", 32'(force_val), 32'h1);
        tick();
        chk("ar_first_hold", 32'(force_en), 32'h1);
        tick();
        chk("ar_first_done", 32'(done), 32'h1);
        tick();
        chk("ar_gap_force_en", 32'(force_en), 32'h0);
        tick();
        chk("ar_second_gnt", 32'(gnt), 32'h8);
        chk("ar_second_val", 32'(force_val), 32'h0);
        req = 4'b0000;
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
